// File: rtl/tff_counter_pkg.sv
// Shared types and constants for the T-flip-flop counter family.
package tff_counter_pkg;

  // 2'b11 is never entered; the controller maps it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 3;

endpackage

// File: rtl/tff_n.sv
// Single T flip-flop: holds on T=0, toggles on T=1, async active-low clear.
module tff_n (
  input  logic clk,
  input  logic reset,
  input  logic T,
  output logic Q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/tff_down_counter.sv
// Loadable down counter built from T flip-flops, with one-shot / auto-reload
// terminal-count handling. Define TFF_DOWN_COUNTER_UPDN_EN to add a dir input.
module tff_down_counter
  import tff_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
`ifdef TFF_DOWN_COUNTER_UPDN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             running,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] step_count;
  logic [WIDTH-1:0] toggle;
  logic             terminal;
  logic             running_q;
  logic             tc_q, tc_d;

`ifdef TFF_DOWN_COUNTER_UPDN_EN
  assign terminal   = dir ? (count == {WIDTH{1'b1}}) : (count == '0);
  assign step_count = dir ? (count + ONE) : (count - ONE);
`else
  assign terminal   = (count == '0);
  assign step_count = count - ONE;
`endif

  always_comb begin
    next_count = count;
    reload_d   = reload_q;
    state_d    = state_q;
    tc_d       = 1'b0;
    if (load) begin
      next_count = load_val;
      reload_d   = load_val;
      state_d    = RUN;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (en) begin
            if (terminal) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                next_count = reload_q;
              end else begin
                state_d = DONE;
              end
            end else begin
              next_count = step_count;
            end
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Count bits only ever change through their toggle enables.
  assign toggle = count ^ next_count;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_n u_tff (
      .clk   (clk),
      .reset (reset),
      .T     (toggle[i]),
      .Q     (count[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      reload_q  <= '0;
      running_q <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      reload_q  <= reload_d;
      running_q <= (state_d == RUN);
      tc_q      <= tc_d;
    end
  end

  assign zero     = (count == '0);
  assign running  = running_q;
  assign tc_pulse = tc_q;

endmodule

// File: tb/tb_tff_down_counter.sv
// Bench for tff_down_counter: table vectors, hand sequences and random stimulus
// checked against a cycle-level behavioural model of the counter.
module tb_tff_down_counter;

  localparam int W    = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         resetN;
  logic         load;
  logic [W-1:0] loadVal;
  logic         en;
  logic         autoReload;
  logic [W-1:0] count;
  logic         zero;
  logic         running;
  logic         tcPulse;
`ifdef TFF_DOWN_COUNTER_UPDN_EN
  logic         dir = 1'b0;
`endif

  always #5 clk = ~clk;

  tff_down_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (resetN),
    .load        (load),
    .load_val    (loadVal),
    .en          (en),
    .auto_reload (autoReload),
`ifdef TFF_DOWN_COUNTER_UPDN_EN
    .dir         (dir),
`endif
    .count       (count),
    .zero        (zero),
    .running     (running),
    .tc_pulse    (tcPulse)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Model: phase 0 = idle, 1 = counting, 2 = finished one-shot.
  int mCount  = 0;
  int mReload = 0;
  int mPhase  = 0;
  int mTc     = 0;

  typedef struct {
    bit ld;
    int val;
    bit en;
    bit ar;
    int expCount;
    int expRun;
    int expTc;
  } vec_t;

  vec_t vecs[$];

  task automatic modelReset();
    mCount  = 0;
    mReload = 0;
    mPhase  = 0;
    mTc     = 0;
  endtask

  task automatic modelStep();
    bit goingUp;
    bit atEnd;
    goingUp = 1'b0;
`ifdef TFF_DOWN_COUNTER_UPDN_EN
    goingUp = dir;
`endif
    atEnd = goingUp ? (mCount == MAXV) : (mCount == 0);
    if (load) begin
      mCount  = int'(loadVal);
      mReload = int'(loadVal);
      mPhase  = 1;
      mTc     = 0;
    end else if (mPhase == 1 && en) begin
      if (atEnd) begin
        mTc = 1;
        if (autoReload) mCount = mReload;
        else mPhase = 2;
      end else begin
        mCount = goingUp ? mCount + 1 : mCount - 1;
        mTc    = 0;
      end
    end else begin
      mTc = 0;
    end
  endtask

  task automatic check1(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, " count"},   int'(count),   mCount);
    check1({tag, " running"}, int'(running), (mPhase == 1) ? 1 : 0);
    check1({tag, " tc"},      int'(tcPulse), mTc);
    check1({tag, " zero"},    int'(zero),    (mCount == 0) ? 1 : 0);
  endtask

  // Drive away from the active edge, advance the model, sample just after.
  task automatic applyStimulus(input bit l, input int v, input bit e, input bit ar);
    @(negedge clk);
    load       = l;
    loadVal    = W'(v);
    en         = e;
    autoReload = ar;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN     = 1'b0;
    load       = 1'b0;
    loadVal    = '0;
    en         = 1'b0;
    autoReload = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    check1("reset count",   int'(count),   0);
    check1("reset running", int'(running), 0);
    check1("reset tc",      int'(tcPulse), 0);
    check1("reset zero",    int'(zero),    1);
    @(negedge clk);
    resetN = 1'b1;

    vecs.push_back('{0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 5, 0, 0, 5, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 4, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 3, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 2, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{1, 2, 1, 1, 2, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 1, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 2, 1, 1});
    vecs.push_back('{0, 0, 1, 1, 1, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 2, 1, 1});
    vecs.push_back('{1, 3, 0, 0, 3, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 2, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 2, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 2, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{1, 6, 1, 0, 6, 1, 0});
    vecs.push_back('{1, 0, 1, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 0, 1, 1});
    vecs.push_back('{0, 0, 1, 1, 0, 1, 1});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 0});

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].ld, vecs[i].val, vecs[i].en, vecs[i].ar);
      check1({tag, " table count"},   int'(count),   vecs[i].expCount);
      check1({tag, " table running"}, int'(running), vecs[i].expRun);
      check1({tag, " table tc"},      int'(tcPulse), vecs[i].expTc);
      checkOutput({tag, " model"});
    end

    // Asynchronous reset in the middle of a count must clear before any edge.
    applyStimulus(1, 5, 0, 0);
    applyStimulus(0, 0, 1, 0);
    check1("pre-reset count", int'(count), 4);
    @(negedge clk);
    #2;
    resetN = 1'b0;
    modelReset();
    #1;
    check1("async reset count",   int'(count),   0);
    check1("async reset running", int'(running), 0);
    check1("async reset tc",      int'(tcPulse), 0);
    @(posedge clk);
    #1;
    checkOutput("held in reset");
    @(negedge clk);
    resetN = 1'b1;
    applyStimulus(0, 0, 1, 1);
    checkOutput("idle after reset a");
    applyStimulus(0, 0, 1, 0);
    checkOutput("idle after reset b");
    check1("idle after reset count", int'(count), 0);

`ifdef TFF_DOWN_COUNTER_UPDN_EN
    dir = 1'b1;
    applyStimulus(1, 6, 0, 1);
    check1("updn load", int'(count), 6);
    applyStimulus(0, 0, 1, 1);
    check1("updn up7", int'(count), 7);
    applyStimulus(0, 0, 1, 1);
    check1("updn reload6", int'(count), 6);
    check1("updn reload tc", int'(tcPulse), 1);
    applyStimulus(0, 0, 1, 1);
    check1("updn up7 again", int'(count), 7);
    dir = 1'b0;
    applyStimulus(0, 0, 1, 1);
    check1("updn down6", int'(count), 6);
    check1("updn down tc", int'(tcPulse), 0);
    applyStimulus(0, 0, 1, 1);
    check1("updn down5", int'(count), 5);
    checkOutput("updn model");
`endif

    for (int n = 0; n < 400; n++) begin
`ifdef TFF_DOWN_COUNTER_UPDN_EN
      dir = 1'($urandom_range(0, 1));
`endif
      applyStimulus($urandom_range(0, 9) == 0,
                    int'($urandom_range(0, MAXV)),
                    $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)));
      checkOutput($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/tff_down_counter.md
Name: tff_down_counter

Overview:
- Loadable, enable-gated down counter with terminal-count signalling. Complements the existing T-flip-flop up counter.
- Every count bit is held in a T flip-flop. Next-state is expressed as toggle enables (T = current ^ next).
- Supports one-shot and auto-reload modes. Serves as a programmable interval timer/divider beside the up counter.

Parameters:
- WIDTH, 3, counter width in bits (>=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset; 0 = reset asserted.
- load  in  1  load load_val into count and reload register; priority over en.
- load_val  in  WIDTH  value loaded on load.
- en  in  1  count enable; decrement when high in RUN.
- auto_reload  in  1  1 = reload on terminal, 0 = one-shot; sampled at terminal event.
- count  out  WIDTH  current count (TFF outputs).
- zero  out  1  combinational, count == 0.
- running  out  1  registered, high in RUN state.
- tc_pulse  out  1  registered one-cycle terminal-count pulse.

Behaviour:
- Reset (reset=0, async): count=0, reload_reg=0, state IDLE, running=0, tc_pulse=0. Takes effect immediately, including mid-count.
- States: IDLE, RUN, DONE.
- IDLE: count holds. load -> count=load_val, reload_reg=load_val, go RUN.
- RUN, load=0, en=0: count, state and reload_reg hold. tc_pulse=0.
- RUN, load=0, en=1, count!=0: count <= count-1 (modulo 2^WIDTH arithmetic never wraps here).
- RUN, load=0, en=1, count==0: terminal event.
  - auto_reload=1: count <= reload_reg, stay RUN.
  - auto_reload=0: count holds 0, go DONE.
  - In both cases tc_pulse=1 in the following cycle.
- DONE: count holds 0, running=0. load -> as in IDLE, go RUN. en ignored.
- load in any state: count=load_val, reload_reg=load_val, state RUN, tc_pulse=0 next cycle. A load coincident with a terminal event suppresses the tc_pulse.
- Period in auto-reload = reload_reg+1 enabled cycles. load_val=0 with auto_reload=1 and en=1 gives tc_pulse continuously high.
- tc_pulse: registered. High exactly one cycle after each terminal edge, coincident with the reloaded/held count.
- Count bits: WIDTH instances of the TFF sub-module. T[i] = count[i] ^ next_count[i]. No direct D-load of count bits.
- Latency: load to visible count 1 cycle. Terminal to tc_pulse 1 cycle.

Optional Feature:
- Macro TFF_DOWN_COUNTER_UPDN_EN.
- Defined: adds input port dir (1 bit; 1=up, 0=down), sampled per enabled cycle.
  - In up mode, the terminal event is count == all-ones. Reload and one-shot rules are identical, except that one-shot DONE holds all-ones.
  - zero output unchanged.
- Undefined: no dir port, down-only behaviour above. Logic for up mode is absent.

Decomposition:
- Package tff_counter_pkg contains:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10, 2'b11 unreachable and recovers to IDLE.
  - DEFAULT_WIDTH=3 constant.
- Sub-module tff_n: single T flip-flop with async active-low reset to 0. Ports clk, reset, T, Q. Hold on T=0, toggle on T=1.

Test Plan:
- WIDTH=3, reset=0 asserted asynchronously mid-count at count=4 -> count=0, running=0, tc_pulse=0 before next clk edge. Stays so until load after release.
- load_val=5, auto_reload=0, en=1 -> count 5,4,3,2,1,0, then DONE, tc_pulse=1 for one cycle, count holds 0, running=0. Further en has no effect.
- load_val=2, auto_reload=1, en=1 -> count 2,1,0,2,1,0,2. tc_pulse high on each cycle showing reloaded 2 (every 3 cycles).
- load_val=3, en pattern 1,0,0,1 -> count 3,2,2,2,1. tc_pulse never asserted while en=0 at count 0.
- count=0 in RUN, en=1, load=1, load_val=6 same cycle -> count=6, tc_pulse stays 0, running=1.
- With TFF_DOWN_COUNTER_UPDN_EN, dir=1, auto_reload=1, load_val=6 -> count 6,7,6,7. tc_pulse with each 6 after 7. Switch dir=0 at 7 -> 6,5.
